// File: rtl/route_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : route_ctl_if
//  Description : Handshake bundle between the input channel, the routing
//                controller, the output allocator and the crossbar.
//                slave  - routing controller side (route_ctl)
//                master - surrounding router side (channel/allocator/crossbar)
//  Signals     : in_vld/in_rdy/in_data/in_head/in_tail  input flit channel
//                out_req/out_gnt                         allocator request/grant
//                out_vld/out_rdy/out_data/out_tail       buffered flit to crossbar
//                err                                     dropped-flit pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface route_ctl_if #(
    parameter int DW = 32
);
    logic          in_vld;
    logic          in_rdy;
    logic [DW-1:0] in_data;
    logic          in_head;
    logic          in_tail;
    logic [4:0]    out_req;
    logic          out_gnt;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] out_data;
    logic          out_tail;
    logic          err;

    modport slave (
        input  in_vld, in_data, in_head, in_tail, out_gnt, out_rdy,
        output in_rdy, out_req, out_vld, out_data, out_tail, err
    );

    modport master (
        output in_vld, in_data, in_head, in_tail, out_gnt, out_rdy,
        input  in_rdy, out_req, out_vld, out_data, out_tail, err
    );
endinterface
`default_nettype wire

// File: rtl/route_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : route_ctl
//  Description : Per-input-port XY dimension-order routing controller. Routes
//                the head flit from its relative hop address, decrements the
//                hop count of the chosen dimension, holds the crossbar request
//                until the tail flit leaves and buffers one flit.
//  Ports       : clk, rst (sync, active-high)
//                bus (route_ctl_if.slave) - flit channel, allocator request and
//                grant, buffered output flit, err pulse
//  Parameters  : DW   flit width (>= ALSB+16)
//                ALSB LSB of the 16-bit address field in a head flit
//  Revision    : 1.0 - initial release
// ============================================================================
module route_ctl #(
    parameter int DW   = 32,
    parameter int ALSB = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    route_ctl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FWD  = 2'd2
    } state_t;

    // One-hot output ports, bit order {L,W,E,S,N}
    localparam logic [4:0] C_DIR_L = 5'b10000;
    localparam logic [4:0] C_DIR_W = 5'b01000;
    localparam logic [4:0] C_DIR_E = 5'b00100;
    localparam logic [4:0] C_DIR_S = 5'b00010;
    localparam logic [4:0] C_DIR_N = 5'b00001;

    state_t        state_q, state_d;
    logic          buf_vld_q, buf_vld_d;
    logic [DW-1:0] buf_data_q, buf_data_d;
    logic          buf_tail_q, buf_tail_d;
    logic [4:0]    dir_q, dir_d;
    logic          tail_seen_q, tail_seen_d;
    logic          err_q, err_d;

    logic [15:0]   w_addr;
    logic [15:0]   w_rt_addr;
    logic [4:0]    w_rt_dir;
    logic [DW-1:0] w_rt_data;
    logic          w_in_rdy;
    logic [4:0]    w_out_req;
    logic          w_out_vld;
    logic          w_drain;

    // XY routing of the incoming flit; only meaningful for a head in IDLE.
    // Sign bits are left alone; a count is only decremented when non-zero.
    always_comb begin
        w_addr    = bus.in_data[ALSB +: 16];
        w_rt_addr = w_addr;
        w_rt_dir  = C_DIR_L;
        if (w_addr[6:0] != 7'd0) begin
            w_rt_addr[6:0] = w_addr[6:0] - 7'd1;
            w_rt_dir       = w_addr[7] ? C_DIR_W : C_DIR_E;
        end else if (w_addr[14:8] != 7'd0) begin
            w_rt_addr[14:8] = w_addr[14:8] - 7'd1;
            w_rt_dir        = w_addr[15] ? C_DIR_S : C_DIR_N;
        end
        w_rt_data                = bus.in_data;
        w_rt_data[ALSB +: 16]    = w_rt_addr;
    end

    always_comb begin
        state_d     = state_q;
        buf_vld_d   = buf_vld_q;
        buf_data_d  = buf_data_q;
        buf_tail_d  = buf_tail_q;
        dir_d       = dir_q;
        tail_seen_d = tail_seen_q;
        err_d       = 1'b0;
        w_in_rdy    = 1'b0;
        w_out_req   = 5'b00000;
        w_out_vld   = 1'b0;
        w_drain     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_in_rdy = 1'b1;
                if (bus.in_vld) begin
                    if (bus.in_head) begin
                        buf_vld_d   = 1'b1;
                        buf_data_d  = w_rt_data;
                        buf_tail_d  = bus.in_tail;
                        dir_d       = w_rt_dir;
                        tail_seen_d = bus.in_tail;
                        state_d     = ST_REQ;
                    end else begin
                        // Stray body/tail flit: swallow it and flag it
                        err_d = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                w_out_req = dir_q;
                if (bus.out_gnt) begin
                    state_d = ST_FWD;
                end
            end

            ST_FWD: begin
                w_out_req = dir_q;
                w_out_vld = buf_vld_q;
                w_drain   = buf_vld_q & bus.out_rdy;
                // Stop taking flits once the tail is in; the buffer may refill
                // in the same cycle it drains.
                w_in_rdy  = !tail_seen_q & (!buf_vld_q | bus.out_rdy);
                if (bus.in_vld && w_in_rdy) begin
                    buf_vld_d   = 1'b1;
                    buf_data_d  = bus.in_data;
                    buf_tail_d  = bus.in_tail;
                    tail_seen_d = bus.in_tail;
                end else if (w_drain) begin
                    buf_vld_d = 1'b0;
                end
                if (w_drain && buf_tail_q) begin
                    buf_vld_d   = 1'b0;
                    tail_seen_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            buf_vld_q   <= 1'b0;
            buf_data_q  <= '0;
            buf_tail_q  <= 1'b0;
            dir_q       <= 5'b00000;
            tail_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_vld_q   <= buf_vld_d;
            buf_data_q  <= buf_data_d;
            buf_tail_q  <= buf_tail_d;
            dir_q       <= dir_d;
            tail_seen_q <= tail_seen_d;
            err_q       <= err_d;
        end
    end

    // in_rdy is held low while reset is asserted, even though the state
    // register already reads IDLE during the reset cycles.
    assign bus.in_rdy   = w_in_rdy & !rst;
    assign bus.out_req  = w_out_req;
    assign bus.out_vld  = w_out_vld;
    assign bus.out_data = buf_data_q;
    assign bus.out_tail = buf_tail_q;
    assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_route_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_route_ctl
//  Description : Self-checking bench for route_ctl: table of single-flit
//                routing vectors plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_route_ctl;

    localparam int DW = 32;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    route_ctl_if #(.DW(DW)) bus ();

    route_ctl #(.DW(DW), .ALSB(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  req;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] fl[4];
    logic        hd[4];
    logic [31:0] ex[4];
    int          idx;
    int          oidx;
    bit          done;
    bit          last;

    initial begin
        n_vec = 0;
        n_err = 0;

        tbl[0] = '{32'hA5A5_0203, 5'b00100, 32'hA5A5_0202}; // E, x 3->2
        tbl[1] = '{32'hA5A5_8100, 5'b00010, 32'hA5A5_8000}; // S, y -1 -> -0
        tbl[2] = '{32'hA5A5_0000, 5'b10000, 32'hA5A5_0000}; // L
        tbl[3] = '{32'h5A5A_0083, 5'b01000, 32'h5A5A_0082}; // W
        tbl[4] = '{32'h5A5A_0500, 5'b00001, 32'h5A5A_0400}; // N
        tbl[5] = '{32'hFFFF_7F7F, 5'b00100, 32'hFFFF_7F7E}; // E, max counts
        tbl[6] = '{32'h1234_8180, 5'b00010, 32'h1234_8080}; // x=-0 -> Y
        tbl[7] = '{32'h0000_0001, 5'b00100, 32'h0000_0000}; // last X hop
        tbl[8] = '{32'hC3C3_0080, 5'b10000, 32'hC3C3_0080}; // signs only -> L

        rst         = 1'b1;
        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        bus.in_head = 1'b0;
        bus.in_tail = 1'b0;
        bus.out_gnt = 1'b0;
        bus.out_rdy = 1'b0;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        check("rst_in_rdy",   64'(bus.in_rdy),   64'd0);
        check("rst_out_req",  64'(bus.out_req),  64'd0);
        check("rst_out_vld",  64'(bus.out_vld),  64'd0);
        check("rst_out_tail", 64'(bus.out_tail), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_err",      64'(bus.err),      64'd0);
        rst = 1'b0;
        #1;
        check("rel_in_rdy",   64'(bus.in_rdy),   64'd1);
        tick();

        // ---------------- routing table ----------------
        for (int i = 0; i < 9; i++) begin
            bus.in_vld  = 1'b1;
            bus.in_head = 1'b1;
            bus.in_tail = 1'b1;
            bus.in_data = tbl[i].data;
            #1;
            check($sformatf("v%0d_idle_rdy", i), 64'(bus.in_rdy), 64'd1);
            tick();
            bus.in_vld = 1'b0;
            #1;
            check($sformatf("v%0d_req", i),     64'(bus.out_req), 64'(tbl[i].req));
            check($sformatf("v%0d_req_rdy", i), 64'(bus.in_rdy),  64'd0);
            check($sformatf("v%0d_req_vld", i), 64'(bus.out_vld), 64'd0);
            bus.out_gnt = 1'b1;
            tick();
            bus.out_gnt = 1'b0;
            #1;
            check($sformatf("v%0d_vld", i),  64'(bus.out_vld),  64'd1);
            check($sformatf("v%0d_data", i), 64'(bus.out_data), 64'(tbl[i].exp));
            check($sformatf("v%0d_tail", i), 64'(bus.out_tail), 64'd1);
            check($sformatf("v%0d_hold", i), 64'(bus.out_req),  64'(tbl[i].req));
            bus.out_rdy = 1'b1;
            tick();
            bus.out_rdy = 1'b0;
            #1;
            check($sformatf("v%0d_end_req", i), 64'(bus.out_req), 64'd0);
            check($sformatf("v%0d_end_rdy", i), 64'(bus.in_rdy),  64'd1);
        end

        // ---------------- 4-flit packet, out_rdy toggling ----------------
        fl[0] = 32'h1111_0203; hd[0] = 1'b1; ex[0] = 32'h1111_0202;
        fl[1] = 32'hB0D1_0001; hd[1] = 1'b0; ex[1] = 32'hB0D1_0001;
        fl[2] = 32'h2222_0203; hd[2] = 1'b1; ex[2] = 32'h2222_0203; // head bit on body: untouched
        fl[3] = 32'h7A11_FFFF; hd[3] = 1'b0; ex[3] = 32'h7A11_FFFF;
        bus.in_vld  = 1'b1;
        bus.in_head = 1'b1;
        bus.in_tail = 1'b0;
        bus.in_data = fl[0];
        tick();
        bus.in_vld = 1'b0;
        #1;
        check("pk_req", 64'(bus.out_req), 64'b00100);
        bus.out_gnt = 1'b1;
        tick();
        bus.out_gnt = 1'b0;
        idx  = 1;
        oidx = 0;
        done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (!done) begin
                bus.out_rdy = (c % 2 == 0);
                if (idx < 4) begin
                    bus.in_vld  = 1'b1;
                    bus.in_data = fl[idx];
                    bus.in_head = hd[idx];
                    bus.in_tail = (idx == 3);
                end else begin
                    bus.in_vld = 1'b0;
                end
                #1;
                if (idx == 4) check("pk_rdy_after_tail", 64'(bus.in_rdy), 64'd0);
                last = 1'b0;
                if (bus.out_vld && bus.out_rdy) begin
                    if (oidx < 4) begin
                        check($sformatf("pk_data%0d", oidx), 64'(bus.out_data), 64'(ex[oidx]));
                        check($sformatf("pk_tail%0d", oidx), 64'(bus.out_tail), 64'(oidx == 3));
                    end
                    last = (oidx == 3);
                    oidx++;
                end
                if (bus.in_vld && bus.in_rdy) idx++;
                tick();
                if (last) done = 1'b1;
            end
        end
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b0;
        #1;
        check("pk_done",     64'(done),        64'd1);
        check("pk_count",    64'(oidx),        64'd4);
        check("pk_end_req",  64'(bus.out_req), 64'd0);
        check("pk_end_vld",  64'(bus.out_vld), 64'd0);
        check("pk_end_rdy",  64'(bus.in_rdy),  64'd1);

        // ---------------- stray body flit in IDLE ----------------
        bus.in_vld  = 1'b1;
        bus.in_head = 1'b0;
        bus.in_tail = 1'b0;
        bus.in_data = 32'hDEAD_0203;
        #1;
        check("err_in_rdy", 64'(bus.in_rdy), 64'd1);
        check("err_pre",    64'(bus.err),    64'd0);
        tick();
        bus.in_vld = 1'b0;
        #1;
        check("err_pulse",  64'(bus.err),     64'd1);
        check("err_req",    64'(bus.out_req), 64'd0);
        check("err_vld",    64'(bus.out_vld), 64'd0);
        tick();
        check("err_clear",  64'(bus.err),     64'd0);
        check("err_idle",   64'(bus.in_rdy),  64'd1);
        check("err_req2",   64'(bus.out_req), 64'd0);

        // ---------------- grant withheld 10 cycles ----------------
        bus.in_vld  = 1'b1;
        bus.in_head = 1'b1;
        bus.in_tail = 1'b1;
        bus.in_data = 32'h0000_0083;
        tick();
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("wait%0d_req", c), 64'(bus.out_req), 64'b01000);
            check($sformatf("wait%0d_rdy", c), 64'(bus.in_rdy),  64'd0);
            check($sformatf("wait%0d_vld", c), 64'(bus.out_vld), 64'd0);
            tick();
        end
        bus.out_rdy = 1'b0;
        bus.out_gnt = 1'b1;
        tick();
        bus.out_gnt = 1'b0;
        #1;
        check("wait_fwd_vld",  64'(bus.out_vld),  64'd1);
        check("wait_fwd_data", 64'(bus.out_data), 64'h0000_0082);
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;
        #1;
        check("wait_end_req",  64'(bus.out_req),  64'd0);

        // ---------------- reset mid-packet, buffer full ----------------
        bus.in_vld  = 1'b1;
        bus.in_head = 1'b1;
        bus.in_tail = 1'b0;
        bus.in_data = 32'h4444_0500;
        tick();
        bus.in_vld  = 1'b0;
        bus.out_gnt = 1'b1;
        tick();
        bus.out_gnt = 1'b0;
        #1;
        check("mr_full_vld", 64'(bus.out_vld), 64'd1);
        check("mr_full_req", 64'(bus.out_req), 64'b00001);
        rst = 1'b1;
        tick();
        check("mr_req", 64'(bus.out_req), 64'd0);
        check("mr_vld", 64'(bus.out_vld), 64'd0);
        check("mr_rdy", 64'(bus.in_rdy),  64'd0);
        rst = 1'b0;
        #1;
        check("mr_rel_rdy", 64'(bus.in_rdy), 64'd1);
        tick();
        check("mr_idle_rdy",  64'(bus.in_rdy),   64'd1);
        check("mr_idle_req",  64'(bus.out_req),  64'd0);
        check("mr_idle_data", 64'(bus.out_data), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
